// File: rtl/vid_pkg.sv
//------------------------------------------------------------------------------
// vid_pkg - composite DAC levels, DAC source select and gray-level mapping. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package vid_pkg;

  localparam int DAC_W    = 4;
  localparam int FULL_LVL = (1 << DAC_W) - 1;

  localparam logic [DAC_W-1:0] SYNC_LVL  = 4'd0;
  localparam logic [DAC_W-1:0] BLANK_LVL = 4'd4;

  typedef enum logic [1:0] {
    SRC_BLANK  = 2'd0,
    SRC_SYNC   = 2'd1,
    SRC_PIX    = 2'd2,
    SRC_BORDER = 2'd3
  } dac_src_e;

  // Spreads a pix_w-bit gray value evenly between blank and full scale.
  function automatic logic [DAC_W-1:0] pix_level(input logic [2:0] p, input int pix_w);
    int span;
    span = (1 << pix_w) - 1;
    return DAC_W'(int'(BLANK_LVL) + (int'(p) * (FULL_LVL - int'(BLANK_LVL))) / span);
  endfunction

endpackage

`default_nettype wire

// File: rtl/vid_ntsc_timing.sv
//------------------------------------------------------------------------------
// vid_ntsc_timing - pixel tick divider, h/v raster counters, active flags, vblank, frame strobe. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module vid_ntsc_timing
  import vid_pkg::*;
#(
  parameter int DIV     = 5,
  parameter int H_TOTAL = 406,
  parameter int H_START = 50,
  parameter int AW      = 256,
  parameter int V_TOTAL = 262,
  parameter int V_START = 20,
  parameter int AH      = 64,
  parameter int HW      = $clog2(H_TOTAL),
  parameter int VW      = $clog2(V_TOTAL)
) (
  input  logic          clk32mhz_i,
  input  logic          rst_n_i,
  output logic          tick_o,
  output logic [HW-1:0] h_o,
  output logic [VW-1:0] v_o,
  output logic          hact_o,
  output logic          hact_next_o,
  output logic          vact_o,
  output logic          vblank_o,
  output logic          frame_start_o
);

  localparam int             DVW      = $clog2(DIV);
  localparam logic [DVW-1:0] DIV_LAST = DVW'(DIV - 1);

  logic [DVW-1:0] div_q;
  logic [HW-1:0]  h_q, h_d;
  logic [VW-1:0]  v_q, v_d;
  logic           vblank_q;
  logic           frame_start_q;
  logic [31:0]    h32, v32;
  logic           tick, hact, hact_next, vact;

  assign h32       = 32'(h_q);
  assign v32       = 32'(v_q);
  assign tick      = (div_q == DIV_LAST);
  assign hact      = (h32 >= H_START) && (h32 < H_START + AW);
  assign hact_next = (h32 + 32'd1 >= H_START) && (h32 + 32'd1 < H_START + AW);
  assign vact      = (v32 >= V_START) && (v32 < V_START + AH);

  always_comb begin
    h_d = h_q + 1'b1;
    v_d = v_q;
    if (h32 == H_TOTAL - 1) begin
      h_d = '0;
      v_d = (v32 == V_TOTAL - 1) ? '0 : v_q + 1'b1;
    end
  end

  // h_q/v_q name the position being emitted on the next tick; vblank follows it.
  always_ff @(posedge clk32mhz_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      div_q         <= '0;
      h_q           <= '0;
      v_q           <= '0;
      vblank_q      <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= tick && (h_q == '0) && (v_q == '0);
      if (tick) begin
        div_q    <= '0;
        h_q      <= h_d;
        v_q      <= v_d;
        vblank_q <= !vact;
      end else begin
        div_q <= div_q + 1'b1;
      end
    end
  end

  assign tick_o        = tick;
  assign h_o           = h_q;
  assign v_o           = v_q;
  assign hact_o        = hact;
  assign hact_next_o   = hact_next;
  assign vact_o        = vact;
  assign vblank_o      = vblank_q;
  assign frame_start_o = frame_start_q;

endmodule

`default_nettype wire

// File: rtl/vid_ntsc_gen.sv
//------------------------------------------------------------------------------
// vid_ntsc_gen - framebuffer to NTSC composite 4-bit DAC; build option VID_NTSC_BORDER_EN. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module vid_ntsc_gen
  import vid_pkg::*;
#(
  parameter int DIV       = 5,
  parameter int H_TOTAL   = 406,
  parameter int H_SYNC    = 40,
  parameter int H_START   = 50,
  parameter int COLS_LOG2 = 7,
  parameter int SX_LOG2   = 1,
  parameter int V_TOTAL   = 262,
  parameter int V_SYNC    = 3,
  parameter int V_START   = 20,
  parameter int ROWS_LOG2 = 5,
  parameter int SY_LOG2   = 1,
  parameter int PIX_W     = 1
) (
  input  logic                           clk32mhz,
  input  logic                           rst_n,
  input  logic [PIX_W-1:0]               pix,
  output logic [COLS_LOG2+ROWS_LOG2-1:0] adr,
  output logic [DAC_W-1:0]               dac,
  output logic                           vblank,
  output logic                           frame_start
`ifdef VID_NTSC_BORDER_EN
  ,
  input  logic [PIX_W-1:0]               border
`endif
);

  localparam int AW = (1 << COLS_LOG2) << SX_LOG2;
  localparam int AH = (1 << ROWS_LOG2) << SY_LOG2;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  if (DIV < 2 || DIV > 16 || PIX_W < 1 || PIX_W > 3 ||
      H_START + AW > H_TOTAL || V_START + AH > V_TOTAL ||
      H_START <= H_SYNC || V_START < V_SYNC) begin : g_cfg_err
    $error("vid_ntsc_gen: illegal raster geometry or parameter range");
  end

  logic                           tick, hact, hact_next, vact;
  logic [HW-1:0]                  h;
  logic [VW-1:0]                  v;
  logic [31:0]                    h32, v32;
  logic [COLS_LOG2-1:0]           col_next;
  logic [ROWS_LOG2-1:0]           row;
  dac_src_e                       src;
  logic [DAC_W-1:0]               dac_d, dac_q;
  logic [COLS_LOG2+ROWS_LOG2-1:0] adr_q;

  vid_ntsc_timing #(
    .DIV     (DIV),
    .H_TOTAL (H_TOTAL),
    .H_START (H_START),
    .AW      (AW),
    .V_TOTAL (V_TOTAL),
    .V_START (V_START),
    .AH      (AH),
    .HW      (HW),
    .VW      (VW)
  ) u_timing (
    .clk32mhz_i    (clk32mhz),
    .rst_n_i       (rst_n),
    .tick_o        (tick),
    .h_o           (h),
    .v_o           (v),
    .hact_o        (hact),
    .hact_next_o   (hact_next),
    .vact_o        (vact),
    .vblank_o      (vblank),
    .frame_start_o (frame_start)
  );

  assign h32 = 32'(h);
  assign v32 = 32'(v);

  // The address is fetched one tick ahead so pix is ready when the pixel is emitted.
  assign col_next = COLS_LOG2'((h32 + 32'd1 - 32'(H_START)) >> SX_LOG2);
  assign row      = ROWS_LOG2'((v32 - 32'(V_START)) >> SY_LOG2);

`ifdef VID_NTSC_BORDER_EN
  localparam int BORD_LO = (H_START > 8) ? H_START - 8 : 0;
  localparam int BORD_HI = H_START + AW + 8;
`endif

  always_comb begin
    src = SRC_BLANK;
    if (v32 < V_SYNC) begin
      src = (h32 < H_TOTAL - H_SYNC) ? SRC_SYNC : SRC_BLANK;
    end else if (h32 < H_SYNC) begin
      src = SRC_SYNC;
    end else if (hact && vact) begin
      src = SRC_PIX;
`ifdef VID_NTSC_BORDER_EN
    end else if (h32 >= BORD_LO && h32 < BORD_HI) begin
      src = SRC_BORDER;
`endif
    end
  end

  always_comb begin
    dac_d = BLANK_LVL;
    case (src)
      SRC_SYNC:   dac_d = SYNC_LVL;
      SRC_PIX:    dac_d = pix_level(3'(pix), PIX_W);
`ifdef VID_NTSC_BORDER_EN
      SRC_BORDER: dac_d = pix_level(3'(border), PIX_W);
`endif
      default:    dac_d = BLANK_LVL;
    endcase
  end

  always_ff @(posedge clk32mhz or negedge rst_n) begin
    if (!rst_n) begin
      adr_q <= '0;
      dac_q <= BLANK_LVL;
    end else if (tick) begin
      if (hact_next && vact) begin
        adr_q <= {col_next, row};
      end
      dac_q <= dac_d;
    end
  end

  assign adr = adr_q;
  assign dac = dac_q;

endmodule

`default_nettype wire

// File: doc/vid_ntsc_gen.md
# vid_ntsc_gen

Parametrised NTSC-style monochrome/grayscale composite generator driving a 4-bit resistor DAC from a framebuffer. It is the successor to the fixed 128x32 monochrome generator. It generalises pixel clock divide, raster geometry, pixel scaling and pixel depth, and adds true vertical sync pulses, a frame-start strobe and vblank status. It sits between the framebuffer read port and the DAC pins.

## Interface
Parameters:
- `DIV`, 5: clk32mhz cycles per pixel tick; legal range 2..16.
- `H_TOTAL`, 406: ticks per line.
- `H_SYNC`, 40: ticks of horizontal sync at line start.
- `H_START`, 50: tick of the first active pixel.
- `COLS_LOG2`, 7: log2 of framebuffer columns.
- `SX_LOG2`, 1: log2 of ticks per column.
- `V_TOTAL`, 262: lines per frame.
- `V_SYNC`, 3: vertical sync lines, 0..V_SYNC-1.
- `V_START`, 20: first active line.
- `ROWS_LOG2`, 5: log2 of framebuffer rows.
- `SY_LOG2`, 1: log2 of lines per row.
- `PIX_W`, 1: bits per pixel, 1..3.

Ports:
- `clk32mhz` in 1: system clock.
- `rst_n` in 1: reset; asynchronous assert, active-low.
- `pix` in PIX_W: framebuffer data for the last `adr`; valid 1 clk later.
- `adr` out COLS_LOG2+ROWS_LOG2: framebuffer address {col, row}, column-major.
- `dac` out 4: composite level.
- `vblank` out 1: high on lines outside [V_START, V_START+(2^ROWS_LOG2<<SY_LOG2)).
- `frame_start` out 1: one-clk strobe on the tick where h=0, v=0.
- `border` in PIX_W: border gray level. Present only with VID_NTSC_BORDER_EN.

## Operation
- Pixel tick: fires on one clk in every DIV. All counters and outputs update only on a tick.
- `h` counts 0..H_TOTAL-1. On wrap, `v` counts 0..V_TOTAL-1 and wraps to 0.
- Active region:
  - Horizontal: h in [H_START, H_START+AW), where AW = 2^COLS_LOG2<<SX_LOG2.
  - Vertical: v in [V_START, V_START+AH), where AH = 2^ROWS_LOG2<<SY_LOG2.
  - Elaboration error if H_START+AW > H_TOTAL, V_START+AH > V_TOTAL, H_START <= H_SYNC, or V_START < V_SYNC.
- Address:
  - Column = (h+1-H_START)>>SX_LOG2; row = (v-V_START)>>SY_LOG2.
  - `adr` leads the displayed pixel by exactly one tick.
  - Outside the active region, `adr` holds its last value.
- Levels (shared constants): SYNC_LVL=0, BLANK_LVL=4.
  - Pixel level = BLANK_LVL + floor(p*(15-BLANK_LVL)/(2^PIX_W-1)).
  - PIX_W=1 gives 4/15. PIX_W=2 gives 4/7/11/15.
- DAC selection, highest priority first:
  1. v < V_SYNC: SYNC_LVL for h < H_TOTAL-H_SYNC, BLANK_LVL otherwise (broad pulse).
  2. h < H_SYNC: SYNC_LVL.
  3. Active region: pixel level of `pix`.
  4. Otherwise: BLANK_LVL.
- Reset values: h=0, v=0, divider=0, adr=0, dac=BLANK_LVL, vblank=1, frame_start=0.
- Reset mid-line: outputs go to reset values immediately, without waiting for a clock. The first tick after release is DIV clks after deassertion and produces h=0, v=0, frame_start=1.

## Timing
- Tick t (active): `adr` for pixel t+1 is registered.
- `pix` is sampled at tick t+1. `dac` is registered at that tick, so the `dac` to `adr` latency is 1 tick.
- `frame_start` is high for exactly 1 clk32mhz cycle per frame.
- `vblank` changes on the tick at which `v` changes.
- Last active pixel: at h = H_START+AW-1, `dac` shows the pixel. `dac` returns to blank at the next tick.

## Configuration
- `VID_NTSC_BORDER_EN` defined:
  - Adds the `border` port.
  - Non-sync, non-active ticks with v >= V_SYNC and H_START-8 <= h < H_START+AW+8 output the pixel level of `border`.
- Not defined: no `border` port; those ticks output BLANK_LVL.

## Structure
- Package `vid_pkg`: SYNC_LVL, BLANK_LVL, DAC_W=4, and the level-mapping function.
- Sub-module `vid_ntsc_timing`:
  - Contains the divider, the h/v counters, active flags, vblank and frame_start.
  - Parent handles address generation and DAC muxing.

## Test plan
- Default params, pix tied 1 → active lines 20..83:
  - dac=15 for h 50..305; dac=4 for h 40..49 and h 306..405; dac=0 for h 0..39.
- Default params, line 1 → dac=0 for h 0..365 and dac=4 for h 366..405. Check `vblank`=1 on lines 0..19 and 84..261.
- Framebuffer model with 1-clk latency storing adr[11:5]^adr[4:0] → every displayed pixel matches the model pixel for col (h-50)>>1, row (v-20)>>1. No one-tick skew.
- PIX_W=2, pix=0..3 on alternating columns → dac sequence 4, 7, 11, 15.
- rst_n pulsed low at h=200, v=100 → dac=4 and adr=0 within the same cycle. frame_start fires DIV clks after release and then every 406*262*5 clks.
- With VID_NTSC_BORDER_EN, border=1, pix=0 → dac=15 for h 42..49 and h 306..313 on non-sync lines, and dac=4 inside the active area.
